uart_rx_byte: RTL and testbench

- Serial-to-parallel receive stage for the iCEstick host link.
- Samples the `from_pc` UART line at 8N1 and delivers each received byte as a data word plus a one-cycle ready strobe.
- This is the same byte/strobe pair that `tb_sft` drives directly in simulation, so `tb_rx_data`/`tb_rx_data_rdy` is a drop-in stand-in for this block.
- Also flags framing errors and break conditions.

---
 rtl/uart_rx_byte.sv | 158 +++++++++++++++
 tb/tb_uart_rx_byte.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM,
// one-cycle byte strobe, framing-error pulse and break hold-off.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 104,
    parameter int CNT_W        = 12
) (
    input  logic       clk12m,
    input  logic       rst_n,
    input  logic       rx_serial,
    output logic [7:0] rx_data,
    output logic       rx_data_rdy,
    output logic       framing_err,
    output logic       rx_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    state_t           r_state;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_rdy;
    logic             r_ferr;
    logic             r_busy;

    logic             w_rx_s;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_clk_nxt;
    logic [2:0]       w_bit_nxt;
    logic [7:0]       w_shift_nxt;
    logic [7:0]       w_data_nxt;
    logic             w_rdy_nxt;
    logic             w_ferr_nxt;
    logic             w_half_hit;
    logic             w_full_hit;

    assign w_rx_s     = r_sync2;
    assign w_half_hit = (r_clk_cnt == HALF_M1);
    assign w_full_hit = (r_clk_cnt == FULL_M1);

    always_ff @(posedge clk12m or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_serial;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk12m or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_rdy     <= 1'b0;
            r_ferr    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clk_cnt <= w_clk_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_data    <= w_data_nxt;
            r_rdy     <= w_rdy_nxt;
            r_ferr    <= w_ferr_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clk_nxt   = r_clk_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_rdy_nxt   = 1'b0;
        w_ferr_nxt  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = S_START;
                    w_clk_nxt   = '0;
                    w_bit_nxt   = '0;
                end
            end
            S_START: begin
                // Mid-start-bit recheck rejects short glitches.
                if (w_half_hit) begin
                    w_clk_nxt   = '0;
                    w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
                end else begin
                    w_clk_nxt = r_clk_cnt + CNT_ONE;
                end
            end
            S_DATA: begin
                if (w_full_hit) begin
                    w_clk_nxt   = '0;
                    w_shift_nxt = {w_rx_s, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt = r_bit_cnt + 3'd1;
                    end
                end else begin
                    w_clk_nxt = r_clk_cnt + CNT_ONE;
                end
            end
            S_STOP: begin
                if (w_full_hit) begin
                    w_clk_nxt = '0;
                    if (w_rx_s) begin
                        w_data_nxt  = r_shift;
                        w_rdy_nxt   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end else begin
                    w_clk_nxt = r_clk_cnt + CNT_ONE;
                end
            end
            S_BREAK: begin
                if (w_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_clk_nxt   = '0;
                w_bit_nxt   = '0;
            end
        endcase
    end

    assign rx_data     = r_data;
    assign rx_data_rdy = r_rdy;
    assign framing_err = r_ferr;
    assign rx_busy     = r_busy;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 8 clocks per bit.
module tb_uart_rx_byte;

    localparam int CPB = 8;

    logic       clk12m;
    logic       rst_n;
    logic       rx_serial;
    logic [7:0] rx_data;
    logic       rx_data_rdy;
    logic       framing_err;
    logic       rx_busy;

    int tests_run;
    int fails;
    int cyc;
    int rdy_cnt;
    int ferr_cnt;
    int multi_cnt;
    int overlap_cnt;
    int rdy_cyc;
    int start_cyc;
    int busy_hi;
    int lat;
    logic prev_rdy;
    logic prev_ferr;
    logic [7:0] rx_q[$];

    uart_rx_byte #(.CLKS_PER_BIT(CPB), .CNT_W(12)) dut (
        .clk12m     (clk12m),
        .rst_n      (rst_n),
        .rx_serial  (rx_serial),
        .rx_data    (rx_data),
        .rx_data_rdy(rx_data_rdy),
        .framing_err(framing_err),
        .rx_busy    (rx_busy)
    );

    initial clk12m = 1'b0;
    always #5 clk12m = ~clk12m;

    always @(posedge clk12m) cyc <= cyc + 1;

    always @(negedge clk12m) begin
        if (rx_data_rdy) begin
            rdy_cnt++;
            rx_q.push_back(rx_data);
            rdy_cyc = cyc;
            if (prev_rdy) multi_cnt++;
        end
        if (framing_err) begin
            ferr_cnt++;
            if (prev_ferr) multi_cnt++;
        end
        if (rx_data_rdy && framing_err) overlap_cnt++;
        prev_rdy  = rx_data_rdy;
        prev_ferr = framing_err;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        rx_serial = 1'b1;
        repeat (n) @(posedge clk12m);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx_serial = v;
        repeat (CPB) @(posedge clk12m);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic clear_mon();
        rdy_cnt   = 0;
        ferr_cnt  = 0;
        multi_cnt = 0;
        rx_q.delete();
    endtask

    initial begin
        tests_run   = 0;
        fails       = 0;
        cyc         = 0;
        overlap_cnt = 0;
        prev_rdy    = 1'b0;
        prev_ferr   = 1'b0;
        rdy_cyc     = 0;
        start_cyc   = 0;
        clear_mon();
        rst_n     = 1'b0;
        rx_serial = 1'b1;

        // Reset state
        repeat (3) @(negedge clk12m);
        check("rst_data", 32'(rx_data), 32'h00);
        check("rst_rdy", 32'(rx_data_rdy), 32'd0);
        check("rst_ferr", 32'(framing_err), 32'd0);
        check("rst_busy", 32'(rx_busy), 32'd0);
        @(posedge clk12m);
        #1 rst_n = 1'b1;
        idle(10);

        // Single byte and latency
        clear_mon();
        send_frame(8'hA5, 1'b1);
        idle(16);
        lat = rdy_cyc - start_cyc;
        check("a5_cnt", 32'(rdy_cnt), 32'd1);
        check("a5_q", 32'(rx_q.size() > 0 ? rx_q[0] : 8'hxx), 32'hA5);
        check("a5_data", 32'(rx_data), 32'hA5);
        check("a5_ferr", 32'(ferr_cnt), 32'd0);
        check("a5_lat", 32'(lat >= 78 && lat <= 80), 32'd1);

        // Back-to-back frames, no idle gap
        clear_mon();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        idle(16);
        check("b2b_cnt", 32'(rdy_cnt), 32'd3);
        check("b2b_0", 32'(rx_q.size() > 0 ? rx_q[0] : 8'hxx), 32'h00);
        check("b2b_1", 32'(rx_q.size() > 1 ? rx_q[1] : 8'hxx), 32'hFF);
        check("b2b_2", 32'(rx_q.size() > 2 ? rx_q[2] : 8'hxx), 32'h3C);
        check("b2b_width", 32'(multi_cnt), 32'd0);
        check("b2b_ferr", 32'(ferr_cnt), 32'd0);

        // Glitch rejection
        clear_mon();
        busy_hi = 0;
        rx_serial = 1'b0;
        repeat (2) @(posedge clk12m);
        #1 rx_serial = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk12m);
            if (rx_busy) busy_hi++;
        end
        check("gl_busy_seen", 32'(busy_hi > 0), 32'd1);
        check("gl_busy_short", 32'(busy_hi <= 6), 32'd1);
        check("gl_busy_end", 32'(rx_busy), 32'd0);
        check("gl_rdy", 32'(rdy_cnt), 32'd0);
        check("gl_ferr", 32'(ferr_cnt), 32'd0);
        check("gl_data", 32'(rx_data), 32'h3C);

        // Framing error, then break held low
        @(posedge clk12m);
        #1;
        clear_mon();
        send_frame(8'h55, 1'b0);
        repeat (40) @(posedge clk12m);
        #1;
        check("fe_cnt", 32'(ferr_cnt), 32'd1);
        check("fe_width", 32'(multi_cnt), 32'd0);
        check("fe_rdy", 32'(rdy_cnt), 32'd0);
        check("fe_data", 32'(rx_data), 32'h3C);
        check("brk_busy", 32'(rx_busy), 32'd1);
        idle(16);
        check("brk_exit", 32'(rx_busy), 32'd0);
        send_frame(8'h12, 1'b1);
        idle(16);
        check("fe_rec_cnt", 32'(rdy_cnt), 32'd1);
        check("fe_rec_data", 32'(rx_data), 32'h12);
        check("fe_rec_ferr", 32'(ferr_cnt), 32'd1);

        // Reset mid-frame during data bit 4
        clear_mon();
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        rx_serial = 1'b0;
        repeat (4) @(posedge clk12m);
        #1 rst_n = 1'b0;
        rx_serial = 1'b1;
        #2;
        check("mr_busy", 32'(rx_busy), 32'd0);
        check("mr_data", 32'(rx_data), 32'h00);
        check("mr_rdy", 32'(rx_data_rdy), 32'd0);
        repeat (2) @(posedge clk12m);
        #1 rst_n = 1'b1;
        idle(CPB);
        send_frame(8'h81, 1'b1);
        idle(16);
        check("mr_cnt", 32'(rdy_cnt), 32'd1);
        check("mr_q", 32'(rx_q.size() > 0 ? rx_q[0] : 8'hxx), 32'h81);
        check("mr_ferr", 32'(ferr_cnt), 32'd0);
        check("overlap", 32'(overlap_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
